// File: rtl/eeprom_i2c_master.sv
// eeprom_i2c_master: single-master I2C byte engine for a serial EEPROM.
// Executes one bus primitive per accepted command: START, STOP, WRITE byte
// (returns the slave ACK bit) or READ byte (returns data and drives ACK/NACK).
// Ports:
//   clk, reset (async, active low)
//   cmd_valid/cmd_ready   command handshake, cmd = 0 START, 1 STOP, 2 WRITE, 3 READ
//   cmd_wdata, cmd_ack    WRITE byte, READ acknowledge choice
//   rsp_valid             one-cycle completion pulse with rsp_rdata / rsp_nack
//   scl, sda_out, sda_in  bus (sda_out = 1 means released)
module eeprom_i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in
);

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_WRITE = 2'd2;
  localparam logic [1:0] C_READ  = 2'd3;
  localparam logic [7:0] DIV_M1  = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, STOP, BIT_LOW, BIT_HIGH, ACK_LOW, ACK_HIGH, DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;      // clk cycles left in the current bus phase
  logic [4:0] pidx, pidx_n;    // phase index within the command (bit = pidx/2)
  logic [1:0] op;
  logic [7:0] wdata;
  logic       ack;
  logic       err;             // WRITE/READ accepted with no open transaction
  logic       busy;
  logic [7:0] shreg;
  logic       pstart;          // the coming edge begins a new bus phase
  logic       scl_n, sda_n;
  logic [1:0] cur_op;
  logic [7:0] cur_wd;
  logic       cur_ack;

  function automatic logic is_last(input logic [1:0] o, input logic [4:0] p);
    case (o)
      C_START: is_last = (p == 5'd3);
      C_STOP:  is_last = (p == 5'd2);
      default: is_last = (p == 5'd17);
    endcase
  endfunction

  function automatic state_t state_of(input logic [1:0] o, input logic [4:0] p);
    if (o == C_START)      state_of = START;
    else if (o == C_STOP)  state_of = STOP;
    else if (p < 5'd16)    state_of = p[0] ? BIT_HIGH : BIT_LOW;
    else                   state_of = p[0] ? ACK_HIGH : ACK_LOW;
  endfunction

  // On the acceptance edge the latched copies are not yet valid.
  assign cur_op    = (state == IDLE) ? cmd       : op;
  assign cur_wd    = (state == IDLE) ? cmd_wdata : wdata;
  assign cur_ack   = (state == IDLE) ? cmd_ack   : ack;
  assign cmd_ready = (state == IDLE);

  // DONE is the final clk cycle of the last phase, so the registered
  // rsp_valid lands exactly N*CLK_DIV cycles after acceptance. With
  // CLK_DIV=1 the whole last phase is the DONE cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pidx_n  = pidx;
    pstart  = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        if (cmd[1] && !busy) state_n = DONE;
        else begin
          pstart  = 1'b1;
          pidx_n  = 5'd0;
          cnt_n   = DIV_M1;
          state_n = state_of(cmd, 5'd0);
        end
      end
      DONE: state_n = IDLE;
      default: begin
        if (cnt == 8'd0) begin
          pstart  = 1'b1;
          pidx_n  = pidx + 5'd1;
          cnt_n   = DIV_M1;
          state_n = (CLK_DIV == 1 && is_last(op, pidx + 5'd1)) ? DONE
                                                              : state_of(op, pidx + 5'd1);
        end else begin
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1 && is_last(op, pidx)) state_n = DONE;
        end
      end
    endcase
  end

  // Bus levels for the phase that starts on the coming edge.
  always_comb begin
    scl_n = scl;
    sda_n = sda_out;
    if (pstart) begin
      case (cur_op)
        C_START: case (pidx_n[1:0])
          2'd0:    sda_n = 1'b1;
          2'd1:    scl_n = 1'b1;
          2'd2:    sda_n = 1'b0;
          default: scl_n = 1'b0;
        endcase
        C_STOP: case (pidx_n[1:0])
          2'd0:    begin sda_n = 1'b0; scl_n = 1'b0; end
          2'd1:    scl_n = 1'b1;
          default: sda_n = 1'b1;
        endcase
        default: begin
          if (pidx_n[0]) scl_n = 1'b1;
          else begin
            scl_n = 1'b0;
            if (pidx_n[4]) sda_n = (cur_op == C_WRITE) ? 1'b1 : ~cur_ack;
            else           sda_n = (cur_op == C_WRITE) ? cur_wd[~pidx_n[3:1]] : 1'b1;
          end
        end
      endcase
    end else if (state == DONE && !err && op[1]) begin
      // end of a byte: pull scl low and release sda
      scl_n = 1'b0;
      sda_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      pidx      <= 5'd0;
      op        <= C_START;
      wdata     <= 8'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      shreg     <= 8'd0;
      scl       <= 1'b1;
      sda_out   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_nack  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pidx      <= pidx_n;
      scl       <= scl_n;
      sda_out   <= sda_n;
      rsp_valid <= 1'b0;
      if (state == IDLE && cmd_valid) begin
        op    <= cmd;
        wdata <= cmd_wdata;
        ack   <= cmd_ack;
        err   <= cmd[1] & ~busy;
        if (cmd == C_START)     busy <= 1'b1;
        else if (cmd == C_STOP) busy <= 1'b0;
      end
      // last clk cycle of each data high phase
      if (state == BIT_HIGH && cnt == 8'd0 && op == C_READ)
        shreg <= {shreg[6:0], sda_in};
      if (state == DONE) begin
        rsp_valid <= 1'b1;
        rsp_nack  <= err | (op == C_WRITE && sda_in);
        rsp_rdata <= (!err && op == C_READ) ? shreg : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_master.sv
// Bench for eeprom_i2c_master: a behavioural slave drives sda_in, a bus
// monitor decodes START/STOP and the data level at each scl rise, and a
// command-level model predicts latency, response fields and bus bits.
module tb_eeprom_i2c_master;
  localparam int D = 4;
  localparam logic [1:0] C_START = 2'd0, C_STOP = 2'd1, C_WRITE = 2'd2, C_READ = 2'd3;

  logic       clk = 1'b0, reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ack = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       cmd_ready, rsp_valid, rsp_nack, scl, sda_out, sda_in;
  logic [7:0] rsp_rdata;

  int tests = 0, fails = 0;
  logic m_busy = 1'b0;

  always #5 clk = ~clk;

  eeprom_i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_wdata(cmd_wdata), .cmd_ack(cmd_ack), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .scl(scl), .sda_out(sda_out),
    .sda_in(sda_in)
  );

  // slave: 0 = disconnected, 1 = ACKs bytes written to it, 2 = sources rdb
  int         smode = 0;
  logic [7:0] rdb = 8'd0;
  int         pos = 8;   // bit slot within the byte, advanced on scl fall
  logic       pscl = 1'b1, psda = 1'b1;
  int         starts = 0, stops = 0, scl_tog = 0;
  logic       rises[$];

  assign sda_in = (smode == 1) ? (pos != 8) :
                  (smode == 2) ? ((pos < 8) ? rdb[3'(7 - pos)] : 1'b1) : 1'b1;

  always @(negedge clk) begin
    pscl <= scl;
    psda <= sda_out;
    if (scl !== pscl) scl_tog <= scl_tog + 1;
    if (pscl && scl && psda && !sda_out) begin
      starts <= starts + 1;
      pos    <= 8;
    end else if (pscl && scl && !psda && sda_out) stops <= stops + 1;
    else if (pscl && !scl) pos <= (pos == 8) ? 0 : pos + 1;
    if (!pscl && scl) rises.push_back(sda_out);
  end

  function automatic logic [8:0] bits9();
    logic [8:0] v;
    v = 'x;
    if (rises.size() == 9) for (int i = 0; i < 9; i++) v[8-i] = rises[i];
    return v;
  endfunction

  function automatic int exp_lat(input logic [1:0] c, input logic b);
    case (c)
      C_START: return 4 * D;
      C_STOP:  return 3 * D;
      default: return b ? 18 * D : 1;
    endcase
  endfunction

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] wd, input logic ak,
                        output int lat, output logic [7:0] rd, output logic nk,
                        output logic rdy1, output logic rdy_rsp, output logic vld_after);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = c; cmd_wdata = wd; cmd_ack = ak;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rdy1 = cmd_ready;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      if (rsp_valid) begin lat = n - 1; break; end
      @(posedge clk); #1;
    end
    if (lat == 0) lat = -1;
    if (rsp_valid && lat < 0) lat = 0;
    rdy_rsp = cmd_ready; rd = rsp_rdata; nk = rsp_nack;
    @(posedge clk); #1;
    vld_after = rsp_valid;
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests++;
    if ({scl, sda_out, cmd_ready, rsp_valid, rsp_rdata, rsp_nack} !== 13'b1_1_1_0_00000000_0) begin
      fails++;
      $display("FAIL reset_values got %b exp %b",
               {scl, sda_out, cmd_ready, rsp_valid, rsp_rdata, rsp_nack}, 13'b1_1_1_0_00000000_0);
    end
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if ({scl, sda_out, cmd_ready, rsp_valid} !== 4'b1110) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL idle_hold got %0d bad cycles exp 0", bad); end
    m_busy = 1'b0;
  endtask

  task automatic test_start();
    int lat, s0; logic [7:0] rd; logic nk, r1, rr, va;
    s0 = starts;
    do_cmd(C_START, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    m_busy = 1'b1;
    tests++;
    if (lat !== 16) begin fails++; $display("FAIL start_latency got %0d exp 16", lat); end
    tests++;
    if ({r1, rr, va} !== 3'b010) begin fails++; $display("FAIL start_handshake got %b exp 010", {r1, rr, va}); end
    tests++;
    if (starts !== s0 + 1) begin fails++; $display("FAIL start_detect got %0d exp %0d", starts, s0 + 1); end
    tests++;
    if ({scl, sda_out} !== 2'b00) begin fails++; $display("FAIL start_end_bus got %b exp 00", {scl, sda_out}); end
  endtask

  task automatic test_write_a0();
    int lat; logic [7:0] rd; logic nk, r1, rr, va;
    smode = 1; rises.delete();
    do_cmd(C_WRITE, 8'hA0, 1'b0, lat, rd, nk, r1, rr, va);
    tests++;
    if (bits9() !== 9'b1010_0000_1) begin fails++; $display("FAIL write_a0_bits got %b exp 101000001", bits9()); end
    tests++;
    if (lat !== 72) begin fails++; $display("FAIL write_latency got %0d exp 72", lat); end
    tests++;
    if ({nk, rd} !== 9'h000) begin fails++; $display("FAIL write_rsp got nack=%b rdata=%h exp 0/00", nk, rd); end
    tests++;
    if ({scl, sda_out} !== 2'b01) begin fails++; $display("FAIL write_end_bus got %b exp 01", {scl, sda_out}); end
  endtask

  task automatic test_nack_stop();
    int lat, p0; logic [7:0] rd; logic nk, r1, rr, va;
    do_cmd(C_START, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    smode = 0;
    do_cmd(C_WRITE, 8'h55, 1'b0, lat, rd, nk, r1, rr, va);
    tests++;
    if (nk !== 1'b1) begin fails++; $display("FAIL write_nack got %b exp 1", nk); end
    p0 = stops;
    do_cmd(C_STOP, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    m_busy = 1'b0;
    tests++;
    if (lat !== 12) begin fails++; $display("FAIL stop_latency got %0d exp 12", lat); end
    tests++;
    if (stops !== p0 + 1) begin fails++; $display("FAIL stop_detect got %0d exp %0d", stops, p0 + 1); end
    tests++;
    if ({scl, sda_out} !== 2'b11) begin fails++; $display("FAIL stop_end_bus got %b exp 11", {scl, sda_out}); end
  endtask

  task automatic test_read();
    int lat; logic [7:0] rd, b; logic nk, r1, rr, va;
    do_cmd(C_START, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    m_busy = 1'b1;
    smode = 2; rdb = 8'h3C; rises.delete();
    do_cmd(C_READ, 8'h00, 1'b1, lat, rd, nk, r1, rr, va);
    tests++;
    if ({rd, nk} !== {8'h3C, 1'b0}) begin fails++; $display("FAIL read_ack_rsp got %h/%b exp 3c/0", rd, nk); end
    tests++;
    if (bits9() !== 9'b1111_1111_0) begin fails++; $display("FAIL read_ack_bits got %b exp 111111110", bits9()); end
    b = 8'($urandom); rdb = b; rises.delete();
    do_cmd(C_READ, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    tests++;
    if ({rd, nk} !== {b, 1'b0}) begin fails++; $display("FAIL read_nack_rsp got %h/%b exp %h/0", rd, nk, b); end
    tests++;
    if (bits9() !== 9'b1111_1111_1) begin fails++; $display("FAIL read_nack_bits got %b exp 111111111", bits9()); end
    do_cmd(C_STOP, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    m_busy = 1'b0;
  endtask

  task automatic test_no_start();
    int lat, t0; logic [7:0] rd; logic nk, r1, rr, va;
    smode = 1; rises.delete(); t0 = scl_tog;
    do_cmd(C_WRITE, 8'hFF, 1'b0, lat, rd, nk, r1, rr, va);
    tests++;
    if ({lat == 1, nk, rd} !== {1'b1, 1'b1, 8'h00}) begin
      fails++; $display("FAIL nostart_write got lat=%0d nack=%b rdata=%h exp 1/1/00", lat, nk, rd);
    end
    do_cmd(C_READ, 8'h00, 1'b1, lat, rd, nk, r1, rr, va);
    tests++;
    if ({lat == 1, nk, rd, rr} !== {1'b1, 1'b1, 8'h00, 1'b1}) begin
      fails++; $display("FAIL nostart_read got lat=%0d nack=%b rdata=%h rdy=%b exp 1/1/00/1", lat, nk, rd, rr);
    end
    tests++;
    if (scl_tog != t0 || rises.size() != 0 || sda_out !== 1'b1) begin
      fails++; $display("FAIL nostart_bus got %0d toggles exp 0", scl_tog - t0);
    end
  endtask

  // Commands offered while busy must be dropped, not queued.
  task automatic test_ignore();
    int lat, extra, p0; logic [7:0] rd; logic nk, r1, rr, va;
    do_cmd(C_START, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    m_busy = 1'b1; smode = 1; p0 = stops;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_WRITE; cmd_wdata = 8'h5A;
    @(posedge clk); #1;
    cmd = C_STOP;
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      if (n == 30) cmd_valid = 1'b0;
      if (rsp_valid) begin lat = n - 1; break; end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests++;
    if (lat !== 72 || rsp_nack !== 1'b0) begin
      fails++; $display("FAIL ignore_latency got %0d nack=%b exp 72/0", lat, rsp_nack);
    end
    extra = 0;
    repeat (60) begin @(posedge clk); #1; if (rsp_valid || !cmd_ready) extra++; end
    tests++;
    if (extra != 0 || stops != p0) begin fails++; $display("FAIL ignore_queued got %0d cycles exp 0", extra); end
  endtask

  task automatic test_random();
    int lat; logic [7:0] rd, wd, erd; logic nk, ak, r1, rr, va, enk;
    logic [1:0] c; logic [1:0] bus0; logic [8:0] ebits; int s0, p0;
    for (int it = 0; it < 40; it++) begin
      if (m_busy) c = 2'($urandom_range(0, 3));
      else        c = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : C_START;
      wd = 8'($urandom); ak = 1'($urandom); rdb = 8'($urandom);
      smode = (c == C_READ) ? 2 : int'($urandom_range(0, 1));
      rises.delete(); s0 = starts; p0 = stops; bus0 = {scl, sda_out};
      do_cmd(c, wd, ak, lat, rd, nk, r1, rr, va);
      enk = 1'b0; erd = 8'h00; ebits = 'x;
      if (c[1] && !m_busy) enk = 1'b1;
      else if (c == C_WRITE) begin enk = (smode != 1); ebits = {wd, 1'b1}; end
      else if (c == C_READ)  begin erd = rdb; ebits = {8'hFF, ~ak}; end
      tests++;
      if (lat !== exp_lat(c, m_busy) || {r1, rr, va} !== 3'b010) begin
        fails++; $display("FAIL rand_timing it=%0d cmd=%0d got lat=%0d hs=%b exp lat=%0d hs=010",
                          it, c, lat, {r1, rr, va}, exp_lat(c, m_busy));
      end
      tests++;
      if ({rd, nk} !== {erd, enk}) begin
        fails++; $display("FAIL rand_rsp it=%0d cmd=%0d got %h/%b exp %h/%b", it, c, rd, nk, erd, enk);
      end
      tests++;
      if ({rsp_rdata, rsp_nack} !== {erd, enk}) begin
        fails++; $display("FAIL rand_hold it=%0d got %h/%b exp %h/%b", it, rsp_rdata, rsp_nack, erd, enk);
      end
      if (c[1] && m_busy) begin
        tests++;
        if (bits9() !== ebits || {scl, sda_out} !== 2'b01) begin
          fails++; $display("FAIL rand_bits it=%0d got %b bus=%b exp %b bus=01", it, bits9(), {scl, sda_out}, ebits);
        end
      end else if (c[1]) begin
        tests++;
        if (rises.size() != 0 || {scl, sda_out} !== bus0) begin
          fails++; $display("FAIL rand_nobus it=%0d got %0d rises exp 0", it, rises.size());
        end
      end else begin
        tests++;
        if ((c == C_START && (starts != s0 + 1 || {scl, sda_out} !== 2'b00)) ||
            (c == C_STOP  && (stops  != p0 + 1 || {scl, sda_out} !== 2'b11))) begin
          fails++; $display("FAIL rand_cond it=%0d cmd=%0d got starts=%0d stops=%0d bus=%b exp %0d/%0d",
                            it, c, starts - s0, stops - p0, {scl, sda_out}, c == C_START, c == C_STOP);
        end
      end
      if (c == C_START) m_busy = 1'b1;
      else if (c == C_STOP) m_busy = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int lat, n, cnt; logic [7:0] rd; logic nk, r1, rr, va;
    do_cmd(C_START, 8'h00, 1'b0, lat, rd, nk, r1, rr, va);
    smode = 1; rises.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_WRITE; cmd_wdata = 8'($urandom);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (rises.size() < 5 && n < 400) begin @(negedge clk); n++; end
    tests++;
    if (rises.size() != 5) begin fails++; $display("FAIL mid_wait got %0d rises exp 5", rises.size()); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({scl, sda_out, cmd_ready, rsp_valid} !== 4'b1110) begin
      fails++; $display("FAIL mid_reset_async got %b exp 1110", {scl, sda_out, cmd_ready, rsp_valid});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    m_busy = 1'b0;
    cnt = 0;
    repeat (100) begin @(posedge clk); #1; if (rsp_valid || scl !== 1'b1) cnt++; end
    tests++;
    if (cnt != 0) begin fails++; $display("FAIL mid_no_rsp got %0d cycles exp 0", cnt); end
    do_cmd(C_WRITE, 8'h12, 1'b0, lat, rd, nk, r1, rr, va);
    tests++;
    if (lat !== 1 || nk !== 1'b1) begin fails++; $display("FAIL mid_busy_cleared got lat=%0d nack=%b exp 1/1", lat, nk); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_write_a0();
    test_nack_stop();
    test_read();
    test_no_start();
    test_ignore();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
